spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_rx_fifo.sv | 50 +++++
 rtl/spi_slave.sv | 138 +++++++++++++
 tb/tb_spi_slave.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave.
package spi_pkg;

   localparam int unsigned SPI_WORD_W     = 8;
   localparam int unsigned SPI_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StHold
   } spi_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive FIFO for the SPI slave; DEPTH must be a power of two, at least 2.
module spi_rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             sclk_o,
   input  logic             aresetn_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] rdata_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
   logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

   always_comb begin
      do_pop   = pop_i && !empty_o;
      do_push  = push_i && (!full_o || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge sclk_o or negedge aresetn_i) begin
      if (!aresetn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/spi_slave.sv
// SPI slave (mode 0 style: sample on posedge, drive on negedge), one word per cs_i assertion.
// Define SPI_SLAVE_RX_FIFO_EN for a FIFO_DEPTH-entry RX FIFO instead of a single register.
module spi_slave import spi_pkg::*; #(
   parameter int unsigned WORD_W     = SPI_WORD_W,
   parameter int unsigned FIFO_DEPTH = SPI_FIFO_DEPTH
) (
   input  logic              sclk_o,
   input  logic              aresetn_i,
   input  logic              cs_i,
   input  logic              mosi_i,
   output logic              miso_o,
   input  logic [WORD_W-1:0] tx_data_i,
   input  logic              tx_load_i,
   output logic              tx_busy_o,
   output logic [WORD_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              rx_overrun_o,
   input  logic              ovr_clr_i
);

   localparam int unsigned CntW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   spi_state_e        state_q, state_d;
   logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
   logic [WORD_W-2:0] rx_shift_q, rx_shift_d;
   logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
   logic              armed_q, armed_d;
   logic              ovr_q, ovr_d;
   logic [WORD_W-1:0] rx_word;
   logic              sample, last_bit, push, pop, full, drop;

   // A frame may only begin once cs_i has been seen high since reset.
   assign sample   = !cs_i && ((state_q == StIdle && armed_q) || state_q == StShift);
   assign last_bit = sample && (bit_cnt_q == CntW'(WORD_W - 1));
   assign rx_word  = {rx_shift_q, mosi_i};
   assign push     = last_bit;
   assign pop      = rx_valid_o && rx_ready_i;
   assign drop     = push && full && !pop;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      armed_d    = armed_q | cs_i;
      if (cs_i) begin
         state_d    = StIdle;
         bit_cnt_d  = '0;
         rx_shift_d = '0;
      end else if (sample) begin
         state_d    = last_bit ? StHold : StShift;
         bit_cnt_d  = last_bit ? '0 : bit_cnt_q + 1'b1;
         rx_shift_d = rx_word[WORD_W-2:0];
      end
      if (state_q == StIdle && tx_load_i) tx_shift_d = tx_data_i;
      else if (sample)                    tx_shift_d = tx_shift_q << 1;
      // A new overrun takes priority over a clear in the same cycle.
      ovr_d = drop ? 1'b1 : (ovr_clr_i ? 1'b0 : ovr_q);
   end

   always_ff @(posedge sclk_o or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         armed_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         armed_q    <= armed_d;
         ovr_q      <= ovr_d;
      end
   end

   always_ff @(negedge sclk_o or negedge aresetn_i) begin
      if (!aresetn_i) miso_o <= 1'b0;
      else            miso_o <= cs_i ? 1'b0 : tx_shift_q[WORD_W-1];
   end

   assign tx_busy_o    = (state_q != StIdle);
   assign rx_overrun_o = ovr_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
   logic fifo_empty;

   spi_rx_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .sclk_o    (sclk_o),
      .aresetn_i (aresetn_i),
      .push_i    (push),
      .pop_i     (pop),
      .wdata_i   (rx_word),
      .full_o    (full),
      .empty_o   (fifo_empty),
      .rdata_o   (rx_data_o)
   );

   assign rx_valid_o = !fifo_empty;
`else
   logic [WORD_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              unused_depth;

   assign unused_depth = (FIFO_DEPTH != 0);
   assign full         = rx_valid_q;

   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      if (pop) rx_valid_d = 1'b0;
      if (push && (!rx_valid_q || pop)) begin
         rx_data_d  = rx_word;
         rx_valid_d = 1'b1;
      end
   end

   always_ff @(posedge sclk_o or negedge aresetn_i) begin
      if (!aresetn_i) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frames plus a randomized phase against a queue model.
module tb_spi_slave;

   localparam int W = 8;
`ifdef SPI_SLAVE_RX_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic         sclk = 1'b0;
   logic         aresetn;
   logic         cs, mosi, miso;
   logic [W-1:0] tx_data;
   logic         tx_load, tx_busy;
   logic [W-1:0] rx_data;
   logic         rx_valid, rx_ready, rx_overrun, ovr_clr;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] rxq[$];
   logic         ovr_m;
   logic [W-1:0] txm;

   spi_slave #(
      .WORD_W     (W),
      .FIFO_DEPTH (4)
   ) dut (
      .sclk_o       (sclk),
      .aresetn_i    (aresetn),
      .cs_i         (cs),
      .mosi_i       (mosi),
      .miso_o       (miso),
      .tx_data_i    (tx_data),
      .tx_load_i    (tx_load),
      .tx_busy_o    (tx_busy),
      .rx_data_o    (rx_data),
      .rx_valid_o   (rx_valid),
      .rx_ready_i   (rx_ready),
      .rx_overrun_o (rx_overrun),
      .ovr_clr_i    (ovr_clr)
   );

   always #5 sclk = ~sclk;

   initial begin
      #1000000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_buf(input string tag);
      chk({tag, "_valid"}, 32'(rx_valid), 32'(rxq.size() > 0));
      if (rxq.size() > 0) chk({tag, "_data"}, 32'(rx_data), 32'(rxq[0]));
      chk({tag, "_ovr"}, 32'(rx_overrun), 32'(ovr_m));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_miso"}, 32'(miso), 0);
      chk({tag, "_valid"}, 32'(rx_valid), 0);
      chk({tag, "_data"}, 32'(rx_data), 0);
      chk({tag, "_ovr"}, 32'(rx_overrun), 0);
      chk({tag, "_busy"}, 32'(tx_busy), 0);
   endtask

   task automatic load_tx(input logic [W-1:0] v);
      tx_data = v;
      tx_load = 1'b1;
      @(posedge sclk); #1;
      tx_load = 1'b0;
      txm = v;
   endtask

   task automatic pop_one();
      check_buf("pre_pop");
      rx_ready = 1'b1;
      @(posedge sclk); #1;
      rx_ready = 1'b0;
      if (rxq.size() > 0) void'(rxq.pop_front());
   endtask

   task automatic clear_ovr();
      ovr_clr = 1'b1;
      @(posedge sclk); #1;
      ovr_clr = 1'b0;
      ovr_m = 1'b0;
      chk("ovr_clr", 32'(rx_overrun), 0);
   endtask

   // Full frame: master drives word MSB first and collects miso on each posedge.
   task automatic send_frame(input logic [W-1:0] word, input bit pop_last, input bit clr_last,
                             input bit busy_load);
      logic [W-1:0] got;
      logic [W-1:0] exp_miso;
      exp_miso = txm;
      @(posedge sclk); #1;
      cs   = 1'b0;
      mosi = word[W-1];
      for (int i = 0; i < W; i++) begin
         if (i == W - 1) begin
            rx_ready = pop_last;
            ovr_clr  = clr_last;
         end
         if (i == 3 && busy_load) begin
            tx_data = ~exp_miso;
            tx_load = 1'b1;
         end
         @(posedge sclk); #1;
         tx_load  = 1'b0;
         rx_ready = 1'b0;
         ovr_clr  = 1'b0;
         got[W-1-i] = miso;
         if (i < W - 1) mosi = word[W-2-i];
         if (i == 3) chk("busy_mid", 32'(tx_busy), 1);
      end
      if (pop_last && rxq.size() > 0) void'(rxq.pop_front());
      if (clr_last) ovr_m = 1'b0;
      if (rxq.size() < CAP) rxq.push_back(word);
      else                  ovr_m = 1'b1;
      txm = '0;
      chk("miso_word", 32'(got), 32'(exp_miso));
      chk("busy_hold", 32'(tx_busy), 1);
      check_buf("frame");
      // Extra edges in HOLD must not sample anything.
      for (int i = 0; i < 3; i++) begin
         mosi = 1'($urandom);
         @(posedge sclk); #1;
      end
      check_buf("hold");
      cs = 1'b1;
      @(posedge sclk); #1;
      chk("busy_end", 32'(tx_busy), 0);
      chk("miso_idle", 32'(miso), 0);
   endtask

   task automatic partial_frame(input logic [W-1:0] word, input int n);
      @(posedge sclk); #1;
      cs   = 1'b0;
      mosi = word[W-1];
      for (int i = 0; i < n; i++) begin
         @(posedge sclk); #1;
         mosi = word[W-2-i];
      end
      txm = txm << n;
   endtask

   initial begin
      logic [W-1:0] w;
      aresetn  = 1'b0;
      cs       = 1'b1;
      mosi     = 1'b0;
      tx_data  = '0;
      tx_load  = 1'b0;
      rx_ready = 1'b0;
      ovr_clr  = 1'b0;
      ovr_m    = 1'b0;
      txm      = '0;
      #12;
      check_reset("reset");
      @(posedge sclk); #1;
      aresetn = 1'b1;
      repeat (2) @(posedge sclk);
      #1;

      // Plain receive with no TX load: miso must be all zeros.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      pop_one();
      check_buf("after_a5");

      load_tx(8'h3C);
      send_frame(W'($urandom), 1'b0, 1'b0, 1'b0);
      pop_one();

      // Abort after 5 bits, then a clean frame.
      partial_frame(8'h5A, 5);
      cs = 1'b1;
      @(posedge sclk); #1;
      chk("abort_busy", 32'(tx_busy), 0);
      check_buf("abort");
      send_frame(8'h81, 1'b0, 1'b0, 1'b0);
      pop_one();

      // Overflow: CAP+1 frames with no consumer.
      for (int k = 1; k <= CAP + 1; k++) begin
         w = (CAP == 1) ? W'(8'h11 * k) : W'(k);
         send_frame(w, 1'b0, 1'b0, 1'b0);
      end
      chk("ovr_set", 32'(rx_overrun), 1);
      for (int k = 0; k < CAP; k++) pop_one();
      check_buf("drained");
      clear_ovr();

      // Push and pop on the same edge with a full buffer: no overrun.
      for (int k = 0; k < CAP; k++) send_frame(W'($urandom), 1'b0, 1'b0, 1'b0);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
      chk("pushpop_ovr", 32'(rx_overrun), 0);
      while (rxq.size() > 0) pop_one();

      // Overrun in the same cycle as a clear keeps the flag set.
      for (int k = 0; k < CAP; k++) send_frame(W'($urandom), 1'b0, 1'b0, 1'b0);
      send_frame(8'h99, 1'b0, 1'b0, 1'b0);
      send_frame(8'h66, 1'b0, 1'b1, 1'b0);
      chk("ovr_clr_race", 32'(rx_overrun), 1);
      clear_ovr();
      while (rxq.size() > 0) pop_one();

      // tx_load during a frame is ignored.
      load_tx(8'hE7);
      send_frame(8'h42, 1'b0, 1'b0, 1'b1);
      pop_one();

      // Reset mid-frame, cs held low through release: no frame may start.
      load_tx(8'hFF);
      partial_frame(8'h0F, 4);
      aresetn = 1'b0;
      #2;
      check_reset("mid_reset");
      rxq.delete();
      ovr_m = 1'b0;
      txm   = '0;
      @(posedge sclk); #1;
      aresetn = 1'b1;
      repeat (3) @(posedge sclk);
      #1;
      chk("post_rst_busy", 32'(tx_busy), 0);
      chk("post_rst_valid", 32'(rx_valid), 0);
      cs = 1'b1;
      @(posedge sclk); #1;
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      pop_one();

      // Randomized traffic.
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 1) load_tx(W'($urandom));
         send_frame(W'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                    bit'($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) pop_one();
         if ($urandom_range(0, 4) == 0) clear_ovr();
      end
      while (rxq.size() > 0) pop_one();
      check_buf("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
